// File: rtl/multicycle_datapath.sv
// -----------------------------------------------------------------------------
// multicycle_datapath
//
// Datapath half of the multicycle CPU. Holds PC, IR, MDR, A, B, ALUOut and
// the 32x32 register file, and carries out whatever control word the
// multicycle controller drives each cycle. Sequencing lives entirely in the
// controller; this block only registers, muxes and computes.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   PCWriteCond, PCWrite, IorD,  one-bit control word fields
//   MemRead, MemWrite, MemtoReg,
//   IRWrite, BEQ, ALUSrcA,
//   RegWrite, RegDst
//   PCSrc, ALUOp, ALUSrcB        two-bit control word fields
//   mem_addr                     unified memory address (PC or ALUOut)
//   mem_wdata                    store data, always the B register
//   mem_read, mem_write          MemRead / MemWrite passed straight through
//   mem_rdata                    combinational read data for mem_addr
//   opcode                       IR[31:26], back to the controller
//   zero                         current-cycle ALU result is zero
//   pc_out                       current PC, for debug
// -----------------------------------------------------------------------------
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCWriteCond,
    input  logic        PCWrite,
    input  logic        IorD,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        IRWrite,
    input  logic        BEQ,
    input  logic        ALUSrcA,
    input  logic        RegWrite,
    input  logic        RegDst,
    input  logic [1:0]  PCSrc,
    input  logic [1:0]  ALUOp,
    input  logic [1:0]  ALUSrcB,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic [5:0]  opcode,
    output logic        zero,
    output logic [31:0] pc_out
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_fn_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] aluout_q;
    logic [31:0] regs_q [32];

    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [31:0] signExtImm;
    logic [31:0] rsData, rtData;
    logic [31:0] aluInA, aluInB, aluResult;
    alu_fn_e     aluFn;
    logic        pcLoad;
    logic [31:0] pcTarget;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;

    assign rs         = ir_q[25:21];
    assign rt         = ir_q[20:16];
    assign rd         = ir_q[15:11];
    assign funct      = ir_q[5:0];
    assign signExtImm = {{16{ir_q[15]}}, ir_q[15:0]};

    assign opcode    = ir_q[31:26];
    assign pc_out    = pc_q;
    assign mem_addr  = IorD ? aluout_q : pc_q;
    assign mem_wdata = b_q;
    assign mem_read  = MemRead;
    assign mem_write = MemWrite;

    // Asynchronous read ports; register 0 is hard-wired to zero.
    always_comb begin
        rsData = (rs == 5'd0) ? 32'd0 : regs_q[rs];
        rtData = (rt == 5'd0) ? 32'd0 : regs_q[rt];
    end

    // ALU control: ALUOp 10 hands the choice to the funct field, and any
    // unrecognised funct falls back to add.
    always_comb begin
        aluFn = ALU_ADD;
        case (ALUOp)
            2'b00: aluFn = ALU_ADD;
            2'b01: aluFn = ALU_SUB;
            2'b11: aluFn = ALU_OR;
            default: begin
                case (funct)
                    6'b100000: aluFn = ALU_ADD;
                    6'b100010: aluFn = ALU_SUB;
                    6'b100100: aluFn = ALU_AND;
                    6'b100101: aluFn = ALU_OR;
                    6'b101010: aluFn = ALU_SLT;
                    default:   aluFn = ALU_ADD;
                endcase
            end
        endcase
    end

    // ALU operand muxes and the ALU itself; all arithmetic wraps at 32 bits.
    always_comb begin
        aluInA = ALUSrcA ? a_q : pc_q;
        case (ALUSrcB)
            2'b00:   aluInB = b_q;
            2'b01:   aluInB = 32'd4;
            2'b10:   aluInB = signExtImm;
            default: aluInB = {signExtImm[29:0], 2'b00};
        endcase
        case (aluFn)
            ALU_SUB: aluResult = aluInA - aluInB;
            ALU_AND: aluResult = aluInA & aluInB;
            ALU_OR:  aluResult = aluInA | aluInB;
            ALU_SLT: aluResult = ($signed(aluInA) < $signed(aluInB)) ? 32'd1 : 32'd0;
            default: aluResult = aluInA + aluInB;
        endcase
    end

    assign zero = (aluResult == 32'd0);

    // PC source select and load enable. BEQ=0 inverts the branch sense so the
    // same conditional write serves bne.
    always_comb begin
        case (PCSrc)
            2'b00:   pcTarget = aluResult;
            2'b01:   pcTarget = aluout_q;
            2'b10:   pcTarget = {pc_q[31:28], ir_q[25:0], 2'b00};
            default: pcTarget = pc_q;
        endcase
        pcLoad = PCWrite | (PCWriteCond & (BEQ ? zero : ~zero));
        pc_d   = pcLoad ? pcTarget : pc_q;
        ir_d   = IRWrite ? mem_rdata : ir_q;
    end

    // Write-back port selection.
    always_comb begin
        writeAddr = RegDst ? rd : rt;
        writeData = MemtoReg ? mdr_q : aluout_q;
    end

    // All state; reset wins over every control input on the same edge.
    // A and B sample the register file before this edge's write lands, so a
    // freshly written value becomes visible to them one edge later.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mem_rdata;
            a_q      <= rsData;
            b_q      <= rtData;
            aluout_q <= aluResult;
            if (RegWrite && (writeAddr != 5'd0)) begin
                regs_q[writeAddr] <= writeData;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// -----------------------------------------------------------------------------
// tb_multicycle_datapath
//
// Self-checking bench for multicycle_datapath. A behavioural model of the
// architectural state (PC, IR, MDR, A, B, ALUOut, register array) predicts
// every output each cycle; directed instruction sequences add checks against
// known constant results, and a randomized phase drives arbitrary control
// words, read data and occasional resets.
// -----------------------------------------------------------------------------
module tb_multicycle_datapath;

    localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;

    typedef struct packed {
        logic       pcWriteCond;
        logic       pcWrite;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memtoReg;
        logic       irWrite;
        logic       beq;
        logic       aluSrcA;
        logic       regWrite;
        logic       regDst;
        logic [1:0] pcSrc;
        logic [1:0] aluOp;
        logic [1:0] aluSrcB;
    } ctrl_t;

    logic        clock = 1'b0;
    logic        reset;
    ctrl_t       ctrl;
    logic [31:0] memRdata;
    logic [31:0] memAddr, memWdata, pcOut;
    logic        memRead, memWrite, zero;
    logic [5:0]  opcode;

    int passCount  = 0;
    int checkCount = 0;

    // Reference state
    logic [31:0] mPc, mIr, mMdr, mA, mB, mAluOut;
    logic [31:0] mRegs [32];

    always #5 clock = ~clock;

    multicycle_datapath #(.RESET_PC(RESET_PC_TB)) dut (
        .clock      (clock),
        .reset      (reset),
        .PCWriteCond(ctrl.pcWriteCond),
        .PCWrite    (ctrl.pcWrite),
        .IorD       (ctrl.iorD),
        .MemRead    (ctrl.memRead),
        .MemWrite   (ctrl.memWrite),
        .MemtoReg   (ctrl.memtoReg),
        .IRWrite    (ctrl.irWrite),
        .BEQ        (ctrl.beq),
        .ALUSrcA    (ctrl.aluSrcA),
        .RegWrite   (ctrl.regWrite),
        .RegDst     (ctrl.regDst),
        .PCSrc      (ctrl.pcSrc),
        .ALUOp      (ctrl.aluOp),
        .ALUSrcB    (ctrl.aluSrcB),
        .mem_addr   (memAddr),
        .mem_wdata  (memWdata),
        .mem_read   (memRead),
        .mem_write  (memWrite),
        .mem_rdata  (memRdata),
        .opcode     (opcode),
        .zero       (zero),
        .pc_out     (pcOut)
    );

    // Single comparison point: counts, and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelReg(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : mRegs[idx];
    endfunction

    // ALU result for the current control word, straight from the operation table.
    function automatic logic [31:0] modelAlu(input ctrl_t c);
        logic [31:0] x, y, imm;
        imm = {{16{mIr[15]}}, mIr[15:0]};
        x = c.aluSrcA ? mA : mPc;
        case (c.aluSrcB)
            2'd0: y = mB;
            2'd1: y = 32'd4;
            2'd2: y = imm;
            default: y = imm * 4;
        endcase
        case (c.aluOp)
            2'd0: return x + y;
            2'd1: return x - y;
            2'd3: return x | y;
            default: begin
                case (mIr[5:0])
                    6'd32: return x + y;
                    6'd34: return x - y;
                    6'd36: return x & y;
                    6'd37: return x | y;
                    6'd42: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                    default: return x + y;
                endcase
            end
        endcase
    endfunction

    task automatic modelReset();
        mPc = RESET_PC_TB;
        mIr = 0; mMdr = 0; mA = 0; mB = 0; mAluOut = 0;
        for (int i = 0; i < 32; i++) mRegs[i] = 0;
    endtask

    // Advance the reference by one rising edge using the inputs now applied.
    task automatic modelUpdate();
        logic [31:0] res, nextPc, newA, newB, wdata;
        logic [4:0]  dst;
        logic        take;
        if (reset) begin
            modelReset();
            return;
        end
        res   = modelAlu(ctrl);
        newA  = modelReg(mIr[25:21]);
        newB  = modelReg(mIr[20:16]);
        dst   = ctrl.regDst ? mIr[15:11] : mIr[20:16];
        wdata = ctrl.memtoReg ? mMdr : mAluOut;
        take  = ctrl.pcWrite || (ctrl.pcWriteCond && (ctrl.beq ? (res == 0) : (res != 0)));
        case (ctrl.pcSrc)
            2'd0: nextPc = res;
            2'd1: nextPc = mAluOut;
            2'd2: nextPc = {mPc[31:28], mIr[25:0], 2'b00};
            default: nextPc = mPc;
        endcase
        if (take) mPc = nextPc;
        mA = newA;
        mB = newB;
        mMdr = memRdata;
        mAluOut = res;
        if (ctrl.irWrite) mIr = memRdata;
        if (ctrl.regWrite && dst != 0) mRegs[dst] = wdata;
    endtask

    // Drive one cycle's inputs and check the combinational outputs.
    task automatic applyStimulus(input ctrl_t c, input logic [31:0] rd, input logic rst);
        logic [31:0] res;
        ctrl = c;
        memRdata = rd;
        reset = rst;
        #1;
        res = modelAlu(c);
        checkOutput("memAddr", memAddr, c.iorD ? mAluOut : mPc);
        checkOutput("memWdata", memWdata, mB);
        checkOutput("memRead", {31'd0, memRead}, {31'd0, c.memRead});
        checkOutput("memWrite", {31'd0, memWrite}, {31'd0, c.memWrite});
        checkOutput("zero", {31'd0, zero}, {31'd0, res == 0});
    endtask

    // Clock edge, model update, registered-output checks.
    task automatic tick();
        @(posedge clock);
        modelUpdate();
        #1;
        checkOutput("pcOut", pcOut, mPc);
        checkOutput("opcode", {26'd0, opcode}, {26'd0, mIr[31:26]});
    endtask

    task automatic cycle(input ctrl_t c, input logic [31:0] rd);
        applyStimulus(c, rd, 1'b0);
        tick();
    endtask

    task automatic doReset();
        ctrl_t c;
        logic [31:0] rnd;
        rnd = $urandom;
        c = rnd[$bits(ctrl_t)-1:0];
        c.regWrite = 1'b1;
        c.pcWrite = 1'b1;
        applyStimulus(c, $urandom, 1'b1);
        tick();
    endtask

    // Load reg[r] with val through IR (rt=r) and MDR.
    task automatic writeReg(input logic [4:0] r, input logic [31:0] val);
        ctrl_t c;
        c = '0; c.irWrite = 1'b1;
        cycle(c, {6'd0, r, r, 16'd0});
        c = '0;
        cycle(c, val);
        c = '0; c.regWrite = 1'b1; c.memtoReg = 1'b1;
        cycle(c, 32'd0);
    endtask

    // Observe reg[r] through B on mem_wdata and compare with a constant.
    task automatic checkReg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        ctrl_t c;
        c = '0; c.irWrite = 1'b1;
        cycle(c, {6'd0, 5'd0, r, 16'd0});
        c = '0;
        cycle(c, 32'd0);
        checkOutput(tag, memWdata, exp);
    endtask

    task automatic fetch(input logic [31:0] instr);
        ctrl_t c;
        c = '0; c.memRead = 1'b1; c.irWrite = 1'b1; c.aluSrcB = 2'b01; c.pcWrite = 1'b1;
        cycle(c, instr);
    endtask

    task automatic decode();
        ctrl_t c;
        c = '0; c.aluSrcB = 2'b11;
        cycle(c, 32'd0);
    endtask

    // Force PC through reg5 + 0 on the ALU.
    task automatic setPc(input logic [31:0] val);
        ctrl_t c;
        writeReg(5'd5, val);
        c = '0;
        cycle(c, 32'd0);
        c = '0; c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.pcWrite = 1'b1;
        cycle(c, 32'd0);
    endtask

    // R-type execute then write-back to rd.
    task automatic rtypeExecWb();
        ctrl_t c;
        c = '0; c.aluSrcA = 1'b1; c.aluOp = 2'b10;
        cycle(c, 32'd0);
        c = '0; c.regDst = 1'b1; c.regWrite = 1'b1;
        cycle(c, 32'd0);
    endtask

    task automatic memAddrCycle();
        ctrl_t c;
        c = '0; c.aluSrcA = 1'b1; c.aluSrcB = 2'b10;
        cycle(c, 32'd0);
    endtask

    // beq/bne $1,$2,3 fetched at PC=8; reg2 stays zero after reset.
    task automatic branchCase(input string tag, input logic beqBit, input logic [31:0] r1,
                              input logic expZero, input logic [31:0] expPc);
        ctrl_t c;
        doReset();
        writeReg(5'd1, r1);
        setPc(32'd8);
        fetch(32'h1022_0003);
        decode();
        c = '0; c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.pcWriteCond = 1'b1;
        c.beq = beqBit; c.pcSrc = 2'b01;
        applyStimulus(c, 32'd0, 1'b0);
        checkOutput({tag, "Zero"}, {31'd0, zero}, {31'd0, expZero});
        tick();
        checkOutput(tag, pcOut, expPc);
    endtask

    initial begin
        ctrl_t c;
        logic [31:0] rnd;

        // First reset with random controls; DUT state is unknown until this edge.
        rnd = $urandom;
        ctrl = rnd[$bits(ctrl_t)-1:0];
        memRdata = $urandom;
        reset = 1'b1;
        @(posedge clock);
        modelReset();
        #1;
        checkOutput("rstPc", pcOut, RESET_PC_TB);
        checkOutput("rstOpcode", {26'd0, opcode}, 32'd0);
        checkOutput("rstWdata", memWdata, 32'd0);
        for (int r = 1; r < 32; r++) begin
            checkReg($sformatf("rstReg%0d", r), r[4:0], 32'd0);
        end

        // add $3,$1,$2 with 7 + 5; PC starts back at zero after a reset.
        doReset();
        writeReg(5'd1, 32'd7);
        writeReg(5'd2, 32'd5);
        fetch(32'h0022_1820);
        checkOutput("fetchPc", pcOut, 32'd4);
        checkOutput("fetchOpcode", {26'd0, opcode}, 32'd0);
        decode();
        rtypeExecWb();
        checkReg("addReg3", 5'd3, 32'd12);

        // slt $3,$1,$2 with -1 < 1
        writeReg(5'd1, 32'hFFFF_FFFF);
        writeReg(5'd2, 32'd1);
        fetch(32'h0022_182A);
        decode();
        rtypeExecWb();
        checkReg("sltReg3", 5'd3, 32'd1);

        // lw $4,8($1) with reg1=100
        writeReg(5'd1, 32'd100);
        fetch(32'h8C24_0008);
        checkOutput("lwOpcode", {26'd0, opcode}, 32'h23);
        decode();
        memAddrCycle();
        c = '0; c.iorD = 1'b1; c.memRead = 1'b1;
        applyStimulus(c, 32'hDEAD_BEEF, 1'b0);
        checkOutput("lwAddr", memAddr, 32'd108);
        checkOutput("lwRead", {31'd0, memRead}, 32'd1);
        tick();
        c = '0; c.memtoReg = 1'b1; c.regWrite = 1'b1;
        cycle(c, 32'd0);
        checkReg("lwReg4", 5'd4, 32'hDEAD_BEEF);

        // sw $4,8($1) to the same address
        fetch(32'hAC24_0008);
        decode();
        memAddrCycle();
        c = '0; c.iorD = 1'b1; c.memWrite = 1'b1;
        applyStimulus(c, 32'd0, 1'b0);
        checkOutput("swAddr", memAddr, 32'd108);
        checkOutput("swWrite", {31'd0, memWrite}, 32'd1);
        checkOutput("swData", memWdata, 32'hDEAD_BEEF);
        tick();

        // Branches: both senses, both outcomes.
        branchCase("beqTaken", 1'b1, 32'd0, 1'b1, 32'd24);
        branchCase("beqNotTaken", 1'b1, 32'd9, 1'b0, 32'd12);
        branchCase("bneNotTaken", 1'b0, 32'd0, 1'b1, 32'd12);
        branchCase("bneTaken", 1'b0, 32'd9, 1'b0, 32'd24);

        // Jump from the 0x4000_0000 region.
        setPc(32'h4000_0000);
        checkOutput("setPc", pcOut, 32'h4000_0000);
        fetch(32'h0800_0010);
        c = '0; c.pcSrc = 2'b10; c.pcWrite = 1'b1;
        cycle(c, 32'd0);
        checkOutput("jumpPc", pcOut, 32'h4000_0040);

        // Write ALUOut=5 to $0; it must still read zero.
        fetch(32'h0000_0005);
        c = '0; c.aluSrcA = 1'b1; c.aluSrcB = 2'b10;
        cycle(c, 32'd0);
        c = '0; c.regWrite = 1'b1;
        cycle(c, 32'd0);
        checkReg("reg0", 5'd0, 32'd0);

        // Reset mid-instruction with writes requested.
        doReset();
        checkOutput("midRstPc", pcOut, RESET_PC_TB);
        checkReg("midRstReg5", 5'd5, 32'd0);

        // Random control words, read data and occasional resets.
        for (int n = 0; n < 400; n++) begin
            rnd = $urandom;
            c = rnd[$bits(ctrl_t)-1:0];
            applyStimulus(c, $urandom, ($urandom_range(0, 19) == 0));
            tick();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Datapath half of the multicycle CPU: holds PC, IR, MDR, A, B, ALUOut and the 32x32 register file, and executes whatever per-cycle control word the multicycle controller drives. It returns the current opcode to the controller and talks to a unified instruction/data memory. The controller decides the sequencing; this block only registers, muxes and computes.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, BEQ, ALUSrcA, RegWrite, RegDst  in  1 each  control word from controller
- PCSrc, ALUOp, ALUSrcB  in  2 each  control word from controller
- mem_addr  out  32  memory address
- mem_wdata  out  32  store data (= B)
- mem_read  out  1  = MemRead
- mem_write  out  1  = MemWrite
- mem_rdata  in  32  combinational read data for mem_addr
- opcode  out  6  IR[31:26], to controller
- zero  out  1  ALU result == 0, current cycle
- pc_out  out  32  current PC (debug)

## Operation
- Fields: opcode IR[31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0], target [25:0].
- mem_addr = IorD ? ALUOut : PC.
- ALU A input = ALUSrcA ? A : PC.
- ALU B input: 00 B; 01 32'd4; 10 sign-extended imm; 11 sign-extended imm << 2.
- ALUOp: 00 add; 01 sub; 11 or; 10 decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1/0); any other funct -> add.
- All arithmetic 32-bit, wrap-around, no overflow trap.
- Every cycle: A <= reg[rs], B <= reg[rt], MDR <= mem_rdata, ALUOut <= ALU result.
- IRWrite=1: IR <= mem_rdata.
- PC next: PCSrc 00 ALU result; 01 ALUOut; 10 {PC[31:28], target, 2'b00}; 11 PC (hold).
- PC loads when PCWrite | (PCWriteCond & (BEQ ? zero : ~zero)). BEQ=0 gives bne behaviour.
- RegWrite=1: reg[RegDst ? rd : rt] <= MemtoReg ? MDR : ALUOut. Writes to register 0 ignored; reg[0] reads 0 always.
- Register file: two asynchronous read ports, one synchronous write port.

## Timing
- Reset (synchronous, rising edge with reset=1): PC=RESET_PC, IR, MDR, A, B, ALUOut = 0, all 32 registers = 0. Hence after reset opcode=0, pc_out=RESET_PC, mem_wdata=0. reset overrides every control input in the same edge.
- Reset mid-instruction: all state reinitialised at that edge; no partial register or PC write commits.
- mem_read, mem_write, mem_addr, mem_wdata, zero: combinational from current state and control; valid same cycle.
- Read-during-write: register written at edge N; A/B latched at edge N capture the old value; new value visible to A/B from edge N+1.
- IRWrite and PC load in the same edge: IR takes mem_rdata addressed by old PC.
- MemRead and MemWrite both 1: both passed through unchanged; arbitration is the memory's job.
- PCWrite=1 and PCWriteCond=1 together: PC loads unconditionally.

## Test plan
- Reset with all controls random -> after edge pc_out=RESET_PC, opcode=0, reg[1..31]=0; controls ignored during reset.
- Fetch: PC=0, mem_rdata=32'h0022_1820 (add $3,$1,$2), IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite=1 -> PC=4, opcode=0, IR=32'h0022_1820.
- R-type: reg1=7, reg2=5, drive decode/execute (ALUSrcA=1, ALUSrcB=00, ALUOp=10) then RegDst=1, MemtoReg=0, RegWrite=1 -> reg3=12; repeat with funct 101010, reg1=-1, reg2=1 -> 1.
- lw/sw: IR=lw $4,8($1), reg1=100; address cycle ALUSrcB=10, then IorD=1 -> mem_addr=108; mem_rdata=32'hDEAD_BEEF, RegDst=0, MemtoReg=1, RegWrite=1 -> reg4=DEADBEEF; sw to same address -> mem_write=1, mem_wdata=reg rt.
- Branch: beq with imm=3 at PC=8 (ALUOut=24 after decode-cycle target calc) -> equal operands, PCWriteCond=1, BEQ=1, PCSrc=01 -> PC=24; unequal -> PC unchanged; BEQ=0 inverts outcome.
- Jump and $0: IR target 26'h000_0010, PCSrc=10, PCWrite=1, PC=32'h4000_0000 -> PC=32'h4000_0040; RegWrite to register 0 with ALUOut=5 -> reg0 still reads 0.
